// File: rtl/jg3_share_arb.sv
// Round-robin arbiter sharing one JG3 code classifier among NREQ requesters.
// One transaction in flight: grant (IDLE), classify (EVAL), deliver (RESP).
module jg3_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_code,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2:0]        rsp_code,
  output logic              rsp_x,
  output logic              rsp_y,
  output logic              busy,
  output logic [7:0]        cnt_x,
  output logic [7:0]        cnt_y
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    r_id;
  logic [2:0]        r_code;
  logic              r_x;
  logic              r_y;
  logic [7:0]        r_cx;
  logic [7:0]        r_cy;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [SW-1:0]     w_sum;
  logic              w_any;
  logic [IDW-1:0]    w_gnt;
  logic [2:0]        w_gcode;
  logic              w_acc;
  logic              w_hs;

  // Rotate so bit 0 is the requester just after the last winner.
  always_comb begin
    w_dbl = {req_valid, req_valid} >> ({1'b0, r_last} + SW'(1));
    w_rot = w_dbl[NREQ-1:0];
    w_any = 1'b0;
    w_sum = '0;
    w_gnt = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_last} + SW'(j + 1);
        if (w_sum >= SW'(NREQ)) begin
          w_sum = w_sum - SW'(NREQ);
        end
        w_gnt = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_gcode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_gcode = req_code[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_EVAL;
      S_EVAL: w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc     = (r_state == S_IDLE) && w_any;
    w_hs      = (r_state == S_RESP) && rsp_ready;
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
    req_ready = w_acc ? (NREQ'(1) << w_gnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDW'(NREQ - 1);
      r_id   <= '0;
      r_code <= '0;
      r_x    <= 1'b0;
      r_y    <= 1'b0;
      r_cx   <= '0;
      r_cy   <= '0;
    end else begin
      if (w_acc) begin
        r_last <= w_gnt;
        r_id   <= w_gnt;
        r_code <= w_gcode;
      end
      if (r_state == S_EVAL) begin
        r_x <= r_code[2] & (r_code[1] | r_code[0]);
        r_y <= (r_code == 3'd0);
      end
      if (w_hs) begin
        if (r_cx != 8'hFF) r_cx <= r_cx + {7'd0, r_x};
        if (r_cy != 8'hFF) r_cy <= r_cy + {7'd0, r_y};
      end
    end
  end

  assign rsp_id   = r_id;
  assign rsp_code = r_code;
  assign rsp_x    = r_x;
  assign rsp_y    = r_y;
  assign cnt_x    = r_cx;
  assign cnt_y    = r_cy;

endmodule

// File: tb/tb_jg3_share_arb.sv
// Scoreboard bench for jg3_share_arb: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_jg3_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_code = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_code;
  logic        rsp_x;
  logic        rsp_y;
  logic        busy;
  logic [7:0]  cnt_x;
  logic [7:0]  cnt_y;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] code;
    logic       x;
    logic       y;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_cx = 0;
  int   m_cy = 0;
  int   last_rc = -1;
  bit   chk_space = 1'b0;

  jg3_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_code(req_code),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_code(rsp_code),
    .rsp_x(rsp_x),
    .rsp_y(rsp_y),
    .busy(busy),
    .cnt_x(cnt_x),
    .cnt_y(cnt_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_id", int'(rsp_id), int'(mon_e.id));
        chk("rsp_code", int'(rsp_code), int'(mon_e.code));
        chk("rsp_x", int'(rsp_x), int'(mon_e.x));
        chk("rsp_y", int'(rsp_y), int'(mon_e.y));
        if (mon_e.x && m_cx < 255) m_cx++;
        if (mon_e.y && m_cy < 255) m_cy++;
        if (chk_space && last_rc >= 0) chk("rsp_spacing", cyc - last_rc, 3);
        last_rc = cyc;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cx = 0;
    m_cy = 0;
  endtask

  task automatic issue(input logic [3:0] mask, input logic [11:0] codes,
                       input int g, input bit x, input bit y);
    exp_t e;
    @(negedge clk);
    req_valid = mask;
    req_code  = codes;
    #1;
    chk("grant", int'(req_ready), 1 << g);
    chk("busy_idle", int'(busy), 0);
    e.id   = 2'(g);
    e.code = 3'(codes >> (3 * g));
    e.x    = x;
    e.y    = y;
    q.push_back(e);
    @(negedge clk);
    chk("eval_valid", int'(rsp_valid), 0);
    chk("eval_ready", int'(req_ready), 0);
    chk("eval_busy", int'(busy), 1);
    @(negedge clk);
    chk("resp_valid", int'(rsp_valid), 1);
  endtask

  task automatic finish_rsp();
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid && rsp_ready) begin
        @(posedge clk);
        #1;
        req_valid = '0;
        return;
      end
      @(negedge clk);
    end
    chk("hs_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_code", int'(rsp_code), 0);
    chk("rst_rsp_xy", int'({rsp_x, rsp_y}), 0);
    chk("rst_cnt_x", int'(cnt_x), 0);
    chk("rst_cnt_y", int'(cnt_y), 0);

    // Single request, code 0
    issue(4'b0001, 12'h000, 0, 1'b0, 1'b1);
    finish_rsp();
    @(negedge clk);
    chk("t1_cnt_y", int'(cnt_y), 1);
    chk("t1_cnt_x", int'(cnt_x), 0);

    // Rotation with all four requesting: codes r3..r0 = 0,7,2,5
    do_reset();
    chk_space = 1'b1;
    last_rc = -1;
    issue(4'b1111, {3'd0, 3'd7, 3'd2, 3'd5}, 0, 1'b1, 1'b0);
    finish_rsp();
    issue(4'b1111, {3'd0, 3'd7, 3'd2, 3'd5}, 1, 1'b0, 1'b0);
    finish_rsp();
    issue(4'b1111, {3'd0, 3'd7, 3'd2, 3'd5}, 2, 1'b1, 1'b0);
    finish_rsp();
    issue(4'b1111, {3'd0, 3'd7, 3'd2, 3'd5}, 3, 1'b0, 1'b1);
    finish_rsp();
    issue(4'b1111, {3'd0, 3'd7, 3'd2, 3'd5}, 0, 1'b1, 1'b0);
    finish_rsp();
    chk_space = 1'b0;
    @(negedge clk);
    chk("t2_cnt_x", int'(cnt_x), 3);
    chk("t2_cnt_y", int'(cnt_y), 1);

    // Exhaustive code sweep on requester 2
    do_reset();
    for (int c = 0; c < 8; c++) begin
      issue(4'b0100, 12'(c << 6), 2, c >= 5, c == 0);
      finish_rsp();
    end
    @(negedge clk);
    chk("t3_cnt_x", int'(cnt_x), 3);
    chk("t3_cnt_y", int'(cnt_y), 1);

    // Backpressure: last=2, so requester 0 (code 6) wins over 1
    rsp_ready = 1'b0;
    issue(4'b0011, {3'd0, 3'd0, 3'd1, 3'd6}, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id", int'(rsp_id), 0);
      chk("bp_x", int'(rsp_x), 1);
      chk("bp_code", int'(rsp_code), 6);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_cnt_x", int'(cnt_x), 3);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    finish_rsp();
    @(negedge clk);
    chk("t4_cnt_x", int'(cnt_x), 4);
    chk("t4_model_x", int'(cnt_x), m_cx);

    // Saturation
    do_reset();
    for (int n = 0; n < 300; n++) begin
      issue(4'b0001, 12'h007, 0, 1'b1, 1'b0);
      finish_rsp();
    end
    @(negedge clk);
    chk("t5_cnt_x", int'(cnt_x), 255);
    chk("t5_cnt_y", int'(cnt_y), 0);
    chk("t5_model_x", int'(cnt_x), m_cx);

    // Reset during RESP drops the response
    rsp_ready = 1'b0;
    issue(4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    void'(q.pop_back());
    m_cx = 0;
    m_cy = 0;
    @(negedge clk);
    chk("t6_rsp_valid", int'(rsp_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_cnt_x", int'(cnt_x), 0);
    chk("t6_cnt_y", int'(cnt_y), 0);
    chk("t6_rsp_id", int'(rsp_id), 0);
    rsp_ready = 1'b1;
    issue(4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}, 0, 1'b0, 1'b0);
    finish_rsp();
    @(negedge clk);
    chk("t6_q_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
